// File: rtl/wisc_pkg.sv
// Shared types for the WISC issue stage: ALU op enum, instruction opcodes,
// control-word payload and immediate-extension helpers.
package wisc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned PERF_W = 32;

  // BGEZ is issued as BLTZ; the execute stage inverts the branch outcome.
  localparam bit OP_BGEZ_VIA_BLTZ = 1'b1;

  typedef enum logic [OP_W-1:0] {
    ADD     = 5'd0,  SUB   = 5'd1,  OP_XOR = 5'd2,  OP_ANDN = 5'd3,
    ROL     = 5'd4,  SLL   = 5'd5,  ROR    = 5'd6,  SRA     = 5'd7,
    SEQ     = 5'd8,  SLT   = 5'd9,  SLE    = 5'd10, SCO     = 5'd11,
    BTR     = 5'd12, LBI   = 5'd13, SLBI   = 5'd14, ST      = 5'd15,
    LD      = 5'd16, STU   = 5'd17, BEQZ   = 5'd18, BNEZ    = 5'd19,
    BLTZ    = 5'd20, J     = 5'd21, JR     = 5'd22, JAL     = 5'd23,
    JALR    = 5'd24, NOP   = 5'd25, SIIC   = 5'd26, RTI     = 5'd27,
    SRL     = 5'd28, HALT  = 5'd29
  } alu_op_e;

  localparam logic [4:0] OPC_HALT  = 5'b00000;
  localparam logic [4:0] OPC_NOP   = 5'b00001;
  localparam logic [4:0] OPC_SIIC  = 5'b00010;
  localparam logic [4:0] OPC_RTI   = 5'b00011;
  localparam logic [4:0] OPC_J     = 5'b00100;
  localparam logic [4:0] OPC_JR    = 5'b00101;
  localparam logic [4:0] OPC_JAL   = 5'b00110;
  localparam logic [4:0] OPC_JALR  = 5'b00111;
  localparam logic [4:0] OPC_ADDI  = 5'b01000;
  localparam logic [4:0] OPC_SUBI  = 5'b01001;
  localparam logic [4:0] OPC_XORI  = 5'b01010;
  localparam logic [4:0] OPC_ANDNI = 5'b01011;
  localparam logic [4:0] OPC_BEQZ  = 5'b01100;
  localparam logic [4:0] OPC_BNEZ  = 5'b01101;
  localparam logic [4:0] OPC_BLTZ  = 5'b01110;
  localparam logic [4:0] OPC_BGEZ  = 5'b01111;
  localparam logic [4:0] OPC_ST    = 5'b10000;
  localparam logic [4:0] OPC_LD    = 5'b10001;
  localparam logic [4:0] OPC_SLBI  = 5'b10010;
  localparam logic [4:0] OPC_STU   = 5'b10011;
  localparam logic [4:0] OPC_ROLI  = 5'b10100;
  localparam logic [4:0] OPC_SLLI  = 5'b10101;
  localparam logic [4:0] OPC_RORI  = 5'b10110;
  localparam logic [4:0] OPC_SRAI  = 5'b10111;
  localparam logic [4:0] OPC_LBI   = 5'b11000;
  localparam logic [4:0] OPC_BTR   = 5'b11001;
  localparam logic [4:0] OPC_SHFT  = 5'b11010;
  localparam logic [4:0] OPC_ALU   = 5'b11011;
  localparam logic [4:0] OPC_SEQ   = 5'b11100;
  localparam logic [4:0] OPC_SLT   = 5'b11101;
  localparam logic [4:0] OPC_SLE   = 5'b11110;
  localparam logic [4:0] OPC_SCO   = 5'b11111;

  typedef struct packed {
    alu_op_e           op;
    logic              sign;
    logic              cin;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              wr_en;
    logic [DATA_W-1:0] pc;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
    return DATA_W'($signed(v));
  endfunction

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    return DATA_W'($signed(v));
  endfunction

  function automatic logic [DATA_W-1:0] sext11(input logic [10:0] v);
    return DATA_W'($signed(v));
  endfunction

endpackage

// File: rtl/alu_issue_decode_comb.sv
// Combinational WISC instruction decoder producing the execute-stage control word.
module issue_decode_comb
  import wisc_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] pc,
  output ctrl_t             ctrl_c
);

  logic [4:0] opc;
  assign opc = instr[15:11];

  always_comb begin
    ctrl_c       = '0;
    ctrl_c.op    = NOP;
    ctrl_c.rs    = instr[10:8];
    ctrl_c.rt    = instr[7:5];
    ctrl_c.pc    = pc;
    ctrl_c.wr_en = 1'b1;
    case (opc)
      OPC_HALT: begin ctrl_c.op = HALT; ctrl_c.wr_en = 1'b0; end
      OPC_NOP:  begin ctrl_c.op = NOP;  ctrl_c.wr_en = 1'b0; end
      OPC_SIIC: begin ctrl_c.op = SIIC; ctrl_c.wr_en = 1'b0; end
      OPC_RTI:  begin ctrl_c.op = RTI;  ctrl_c.wr_en = 1'b0; end
      OPC_J: begin
        ctrl_c.op = J; ctrl_c.imm = sext11(instr[10:0]); ctrl_c.wr_en = 1'b0;
      end
      OPC_JR: begin
        ctrl_c.op = JR; ctrl_c.imm = sext8(instr[7:0]); ctrl_c.use_imm = 1'b1;
        ctrl_c.wr_en = 1'b0;
      end
      OPC_JAL: begin
        ctrl_c.op = JAL; ctrl_c.imm = sext11(instr[10:0]); ctrl_c.rd = 3'd7;
      end
      OPC_JALR: begin
        ctrl_c.op = JALR; ctrl_c.imm = sext8(instr[7:0]); ctrl_c.use_imm = 1'b1;
        ctrl_c.rd = 3'd7;
      end
      // opcode[1:0] selects ADD/SUB/XOR/ANDN; the logical pair zero-extends
      OPC_ADDI, OPC_SUBI, OPC_XORI, OPC_ANDNI: begin
        ctrl_c.op      = alu_op_e'({3'b000, opc[1:0]});
        ctrl_c.imm     = opc[1] ? DATA_W'(instr[4:0]) : sext5(instr[4:0]);
        ctrl_c.use_imm = 1'b1;
        ctrl_c.rd      = instr[7:5];
        ctrl_c.sign    = !opc[1];
        ctrl_c.cin     = (opc[1:0] == 2'b01);
      end
      OPC_BEQZ, OPC_BNEZ, OPC_BLTZ, OPC_BGEZ: begin
        ctrl_c.op    = (opc[1:0] == 2'b00) ? BEQZ : (opc[1:0] == 2'b01) ? BNEZ : BLTZ;
        ctrl_c.imm   = sext8(instr[7:0]);
        ctrl_c.sign  = 1'b1;
        ctrl_c.wr_en = 1'b0;
      end
      OPC_ST, OPC_LD: begin
        ctrl_c.op      = opc[0] ? LD : ST;
        ctrl_c.imm     = sext5(instr[4:0]);
        ctrl_c.use_imm = 1'b1;
        ctrl_c.rd      = instr[7:5];
        ctrl_c.wr_en   = opc[0];
      end
      OPC_STU: begin
        ctrl_c.op = STU; ctrl_c.imm = sext5(instr[4:0]); ctrl_c.use_imm = 1'b1;
        ctrl_c.rd = instr[10:8];
      end
      OPC_SLBI: begin
        ctrl_c.op = SLBI; ctrl_c.imm = DATA_W'(instr[7:0]); ctrl_c.use_imm = 1'b1;
        ctrl_c.rd = instr[10:8];
      end
      OPC_LBI: begin
        ctrl_c.op = LBI; ctrl_c.imm = sext8(instr[7:0]); ctrl_c.use_imm = 1'b1;
        ctrl_c.rd = instr[10:8];
      end
      OPC_ROLI, OPC_SLLI, OPC_RORI, OPC_SRAI: begin
        ctrl_c.op      = alu_op_e'({3'b001, opc[1:0]});
        ctrl_c.imm     = DATA_W'(instr[3:0]);
        ctrl_c.use_imm = 1'b1;
        ctrl_c.rd      = instr[7:5];
      end
      OPC_BTR: begin ctrl_c.op = BTR; ctrl_c.rd = instr[4:2]; end
      OPC_SHFT: begin
        ctrl_c.op = alu_op_e'({3'b001, instr[1:0]}); ctrl_c.rd = instr[4:2];
      end
      OPC_ALU: begin
        ctrl_c.op   = alu_op_e'({3'b000, instr[1:0]});
        ctrl_c.rd   = instr[4:2];
        ctrl_c.sign = !instr[1];
        ctrl_c.cin  = (instr[1:0] == 2'b01);
      end
      OPC_SEQ, OPC_SLT, OPC_SLE, OPC_SCO: begin
        ctrl_c.op   = alu_op_e'({3'b010, opc[1:0]});
        ctrl_c.rd   = instr[4:2];
        ctrl_c.sign = (opc[1:0] == 2'b01) || (opc[1:0] == 2'b10);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_decode.sv
// ID/EX issue stage: decode, output register plus one-entry skid, sticky HALT.
// Optional ISSUE_PERF_CNT_EN adds saturating issue/stall counters.
module alu_issue_decode
  import wisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic              out_sign,
  output logic              out_cin,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_use_imm,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_wr_en,
  output logic [DATA_W-1:0] out_pc,
`ifdef ISSUE_PERF_CNT_EN
  output logic [PERF_W-1:0] perf_issued,
  output logic [PERF_W-1:0] perf_stall,
`endif
  output logic              halted
);

  ctrl_t dec_c, out_q, skid_q, out_d, skid_d;
  logic  skid_valid, out_valid_n, skid_valid_n, halted_n;
  logic  accept_c, consume_c;

  issue_decode_comb u_dec (
    .instr  (in_instr),
    .pc     (in_pc),
    .ctrl_c (dec_c)
  );

  assign accept_c  = in_valid && in_ready;
  assign consume_c = out_valid && out_ready;

  // Next-state for output/skid slots; flush drops everything including this cycle's accept.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_n  = out_valid;
    skid_valid_n = skid_valid;
    halted_n     = halted;
    if (flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      if (consume_c && out_q.op == HALT) halted_n = 1'b1;
      if (consume_c) begin
        if (skid_valid) begin
          out_d        = skid_q;
          skid_valid_n = 1'b0;
        end else if (accept_c) begin
          out_d = dec_c;
        end else begin
          out_valid_n = 1'b0;
        end
      end else if (accept_c) begin
        if (out_valid) begin
          skid_d       = dec_c;
          skid_valid_n = 1'b1;
        end else begin
          out_d       = dec_c;
          out_valid_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      halted     <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_valid  <= out_valid_n;
      skid_valid <= skid_valid_n;
      halted     <= halted_n;
      in_ready   <= !skid_valid_n && !halted_n;
    end
  end

  assign out_op      = out_q.op;
  assign out_sign    = out_q.sign;
  assign out_cin     = out_q.cin;
  assign out_imm     = out_q.imm;
  assign out_use_imm = out_q.use_imm;
  assign out_rs      = out_q.rs;
  assign out_rt      = out_q.rt;
  assign out_rd      = out_q.rd;
  assign out_wr_en   = out_q.wr_en;
  assign out_pc      = out_q.pc;

`ifdef ISSUE_PERF_CNT_EN
  // Saturating counters; untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (consume_c && perf_issued != '1) perf_issued <= perf_issued + PERF_W'(1);
      if (out_valid && !out_ready && perf_stall != '1) perf_stall <= perf_stall + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_decode.sv
// Self-checking bench for alu_issue_decode: directed steps then random traffic
// against a queue-based reference model.
module tb_alu_issue_decode;
  import wisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_instr, in_pc;
  logic [4:0]  out_op;
  logic        out_sign, out_cin, out_use_imm, out_wr_en, halted;
  logic [15:0] out_imm, out_pc;
  logic [2:0]  out_rs, out_rt, out_rd;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  alu_issue_decode dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_sign(out_sign), .out_cin(out_cin), .out_imm(out_imm),
    .out_use_imm(out_use_imm), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_pc(out_pc),
`ifdef ISSUE_PERF_CNT_EN
    .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
    .halted(halted)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  ctrl_t       exp_q[$];
  logic [15:0] got_pc[$];
  logic        m_halted = 1'b0;
  logic        m_in_ready = 1'b1;
  logic        last_accept = 1'b0;
  logic [31:0] m_issued = '0;
  logic [31:0] m_stall = '0;

  alu_op_e br_tab  [4] = '{BEQZ, BNEZ, BLTZ, BLTZ};
  alu_op_e alu_tab [4] = '{ADD, SUB, OP_XOR, OP_ANDN};
  alu_op_e sh_tab  [4] = '{ROL, SLL, ROR, SRA};
  alu_op_e cmp_tab [4] = '{SEQ, SLT, SLE, SCO};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode from the instruction-format rules, using integer sign arithmetic.
  function automatic ctrl_t ref_dec(input logic [15:0] ins, input logic [15:0] pc);
    ctrl_t c;
    int o, s5, s8, s11, f;
    o   = int'(ins[15:11]);
    f   = int'(ins[1:0]);
    s5  = int'(ins[4:0])  - (ins[4]  ? 32   : 0);
    s8  = int'(ins[7:0])  - (ins[7]  ? 256  : 0);
    s11 = int'(ins[10:0]) - (ins[10] ? 2048 : 0);
    c = '0;
    c.op = NOP; c.pc = pc; c.rs = ins[10:8]; c.rt = ins[7:5]; c.wr_en = 1'b1;
    case (o)
      0:  begin c.op = HALT; c.wr_en = 1'b0; end
      1:  begin c.op = NOP;  c.wr_en = 1'b0; end
      2:  begin c.op = SIIC; c.wr_en = 1'b0; end
      3:  begin c.op = RTI;  c.wr_en = 1'b0; end
      4:  begin c.op = J; c.imm = 16'(s11); c.wr_en = 1'b0; end
      5:  begin c.op = JR; c.imm = 16'(s8); c.use_imm = 1'b1; c.wr_en = 1'b0; end
      6:  begin c.op = JAL; c.imm = 16'(s11); c.rd = 3'd7; end
      7:  begin c.op = JALR; c.imm = 16'(s8); c.use_imm = 1'b1; c.rd = 3'd7; end
      8, 9: begin
        c.op = alu_tab[o - 8]; c.imm = 16'(s5); c.use_imm = 1'b1; c.rd = ins[7:5];
        c.sign = 1'b1; c.cin = (o == 9);
      end
      10, 11: begin
        c.op = alu_tab[o - 8]; c.imm = 16'(ins[4:0]); c.use_imm = 1'b1; c.rd = ins[7:5];
      end
      12, 13, 14, 15: begin
        c.op = br_tab[o - 12]; c.imm = 16'(s8); c.sign = 1'b1; c.wr_en = 1'b0;
      end
      16: begin c.op = ST; c.imm = 16'(s5); c.use_imm = 1'b1; c.rd = ins[7:5]; c.wr_en = 1'b0; end
      17: begin c.op = LD; c.imm = 16'(s5); c.use_imm = 1'b1; c.rd = ins[7:5]; end
      18: begin c.op = SLBI; c.imm = 16'(ins[7:0]); c.use_imm = 1'b1; c.rd = ins[10:8]; end
      19: begin c.op = STU; c.imm = 16'(s5); c.use_imm = 1'b1; c.rd = ins[10:8]; end
      20, 21, 22, 23: begin
        c.op = sh_tab[o - 20]; c.imm = 16'(ins[3:0]); c.use_imm = 1'b1; c.rd = ins[7:5];
      end
      24: begin c.op = LBI; c.imm = 16'(s8); c.use_imm = 1'b1; c.rd = ins[10:8]; end
      25: begin c.op = BTR; c.rd = ins[4:2]; end
      26: begin c.op = sh_tab[f]; c.rd = ins[4:2]; end
      27: begin c.op = alu_tab[f]; c.rd = ins[4:2]; c.sign = (f < 2); c.cin = (f == 1); end
      default: begin c.op = cmp_tab[o - 28]; c.rd = ins[4:2]; c.sign = (o == 29 || o == 30); end
    endcase
    return c;
  endfunction

  function automatic ctrl_t obs_word();
    ctrl_t o;
    o.op = alu_op_e'(out_op); o.sign = out_sign; o.cin = out_cin; o.imm = out_imm;
    o.use_imm = out_use_imm; o.rs = out_rs; o.rt = out_rt; o.rd = out_rd;
    o.wr_en = out_wr_en; o.pc = out_pc;
    return o;
  endfunction

  // One clock: advance the model with the current inputs, then compare 1 time unit after the edge.
  task automatic cycle();
    logic  consume, accept, stall;
    ctrl_t d;
    consume = (exp_q.size() > 0) && out_ready;
    stall   = (exp_q.size() > 0) && !out_ready;
    accept  = in_valid && m_in_ready;
    d       = ref_dec(in_instr, in_pc);
    if (out_valid === 1'b1 && out_ready) got_pc.push_back(out_pc);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete(); m_halted = 1'b0; m_in_ready = 1'b1; m_issued = '0; m_stall = '0;
    end else begin
      if (consume) m_issued++;
      if (stall) m_stall++;
      if (flush) begin
        exp_q.delete();
        m_in_ready = !m_halted;
      end else begin
        if (consume) begin
          if (exp_q[0].op == HALT) m_halted = 1'b1;
          void'(exp_q.pop_front());
        end
        if (accept) exp_q.push_back(d);
        m_in_ready = (exp_q.size() < 2) && !m_halted;
      end
    end
    last_accept = accept && !rst && !flush;
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(m_in_ready));
    chk("halted", 64'(halted), 64'(m_halted));
    if (exp_q.size() > 0) chk("ctrl_word", 64'(obs_word()), 64'(exp_q[0]));
`ifdef ISSUE_PERF_CNT_EN
    chk("perf_issued", 64'(perf_issued), 64'(m_issued));
    chk("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
  endtask

  task automatic send(input logic [15:0] ins, input logic [15:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_accept) break;
    end
    chk("accept_timeout", 64'(last_accept), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk(tag, 64'(obs_word()), 64'(0));
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_halted"}, 64'(halted), 64'(0));
  endtask

  initial begin
    logic [15:0] r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    cycle(); cycle();
    check_zero_outputs("reset");
    rst = 1'b0;

    // ADDI r2, r1, -3
    out_ready = 1'b1;
    send(16'h415D, 16'h0102);
    chk("addi_op", 64'(out_op), 64'(0));
    chk("addi_imm", 64'(out_imm), 64'(16'hFFFD));
    chk("addi_use_imm", 64'(out_use_imm), 64'(1));
    chk("addi_rs", 64'(out_rs), 64'(1));
    chk("addi_rd", 64'(out_rd), 64'(2));
    chk("addi_cin", 64'(out_cin), 64'(0));
    chk("addi_sign", 64'(out_sign), 64'(1));
    chk("addi_wr_en", 64'(out_wr_en), 64'(1));

    // SUB r3, r1, r2
    send(16'hD94D, 16'h0104);
    chk("sub_op", 64'(out_op), 64'(1));
    chk("sub_cin", 64'(out_cin), 64'(1));
    chk("sub_use_imm", 64'(out_use_imm), 64'(0));
    chk("sub_rs", 64'(out_rs), 64'(1));
    chk("sub_rt", 64'(out_rt), 64'(2));
    chk("sub_rd", 64'(out_rd), 64'(3));
    cycle();

    // Four-instruction stream against a 3-cycle stall
    got_pc.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'hD94C; in_pc = 16'h0010; cycle();
    chk("skid_ready_after_1", 64'(in_ready), 64'(1));
    in_instr = 16'h415D; in_pc = 16'h0012; cycle();
    chk("skid_ready_after_2", 64'(in_ready), 64'(0));
    in_instr = 16'hC0FF; in_pc = 16'h0014; cycle();
    chk("skid_ready_still_low", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    send(16'hC0FF, 16'h0014);
    send(16'h6005, 16'h0016);
    repeat (4) cycle();
    chk("stream_count", 64'(got_pc.size()), 64'(4));
    if (got_pc.size() == 4) begin
      chk("stream_order", 64'({got_pc[0], got_pc[1], got_pc[2], got_pc[3]}),
          64'h0010_0012_0014_0016);
    end

    // Flush with output and skid full; the flush-cycle instruction is dropped
    out_ready = 1'b0;
    send(16'h4020, 16'h0020);
    send(16'h4040, 16'h0022);
    flush = 1'b1; in_valid = 1'b1; in_instr = 16'h4060; in_pc = 16'h0024; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1; cycle(); cycle();
    chk("flush_no_replay", 64'(out_valid), 64'(0));

    // HALT consumed: sticky halt, intake closed
    send(16'h0000, 16'h0030);
    chk("halt_op", 64'(out_op), 64'(29));
    cycle();
    in_valid = 1'b1; in_instr = 16'h0800;
    repeat (5) cycle();
    chk("halt_sticky", 64'(halted), 64'(1));
    chk("halt_ready_low", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;

    // HALT flushed before consumption never sets halted
    out_ready = 1'b0;
    send(16'h0000, 16'h0040);
    flush = 1'b1; cycle(); flush = 1'b0;
    out_ready = 1'b1; cycle(); cycle();
    chk("flushed_halt", 64'(halted), 64'(0));
    chk("flushed_halt_ready", 64'(in_ready), 64'(1));

    // Reset during a two-entry stall
    out_ready = 1'b0;
    send(16'hD94D, 16'h0050);
    send(16'h415D, 16'h0052);
    rst = 1'b1; cycle(); rst = 1'b0;
    check_zero_outputs("rst_stall");

    // Five stall cycles on a single held entry
    send(16'h415D, 16'h0060);
    repeat (5) cycle();
`ifdef ISSUE_PERF_CNT_EN
    chk("perf_stall5", 64'(perf_stall), 64'(5));
`endif
    out_ready = 1'b1; cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0) || (m_halted && $urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      r         = 16'($urandom);
      if (r[15:11] == 5'd0 && $urandom_range(0, 7) != 0) r[15:11] = 5'd27;
      in_instr  = r;
      in_pc     = 16'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
